// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PAT = 4'b1010;

  // Width needed to hold the values 0..v-1, never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic [W-1:0] w_cnt_n;

  always_comb begin
    w_cnt_n = r_cnt + W'(1);
  end

  // Clear outranks a same-cycle increment; the count stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= w_cnt_n;
      if (w_cnt_n == '1) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: run-time loadable pattern, overlap select,
// qualified input stream and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PAT_RST = DEFAULT_PAT,
  parameter int unsigned           COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               load,
  input  logic [PAT_W-1:0]   pattern,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               y,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat
);

  localparam int unsigned    FW        = clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_y;

  logic             w_accept;
  logic [PAT_W-1:0] w_hist_n;
  logic [FW-1:0]    w_fill_n;
  logic             w_match;

  // fill counts valid history bits since the last restart, so a match is only
  // declared once a full pattern's worth of fresh bits has arrived.
  always_comb begin
    w_accept = din_valid && !load;
    w_hist_n = {r_hist[PAT_W-2:0], din};
    w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
    w_match  = w_accept && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= PAT_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (load) begin
      r_pat  <= pattern;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else if (din_valid) begin
      r_hist <= w_hist_n;
      r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
      r_y    <= w_match;
    end else begin
      r_y    <= 1'b0;
    end
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_match),
    .clr(clr_count),
    .cnt(match_count),
    .sat(count_sat)
  );

  assign y = r_y;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic against
// a queue-based reference model; two instances cover COUNT_W=8 and COUNT_W=2.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       overlap = 1'b1;
  logic       clr_count = 1'b0;

  logic       y_a, y_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       sat_a, sat_b;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W(4), .PAT_RST(4'b1010), .COUNT_W(8)
  ) u_dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
    .pattern(pattern), .overlap(overlap), .clr_count(clr_count),
    .y(y_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detector_param #(
    .PAT_W(4), .PAT_RST(4'b1010), .COUNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .load(load),
    .pattern(pattern), .overlap(overlap), .clr_count(clr_count),
    .y(y_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  // Reference: the bits accepted since the last restart, kept as a queue.
  bit         m_q[$];
  logic [3:0] m_pat = 4'b1010;
  int         m_y = 0;
  int         m_cnt8 = 0, m_sat8 = 0;
  int         m_cnt2 = 0, m_sat2 = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, d, v, l, input logic [3:0] p,
                            input logic o, c);
    int match;
    int val;
    match = 0;
    if (r) begin
      m_pat = 4'b1010;
      m_q.delete();
      m_y = 0;
      m_cnt8 = 0; m_sat8 = 0;
      m_cnt2 = 0; m_sat2 = 0;
      return;
    end
    if (l) begin
      m_pat = p;
      m_q.delete();
      m_y = 0;
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() > 4) void'(m_q.pop_front());
      val = 0;
      foreach (m_q[i]) val = val * 2 + int'(m_q[i]);
      match = (m_q.size() == 4 && val == int'(m_pat)) ? 1 : 0;
      m_y = match;
      if (match != 0 && !o) m_q.delete();
    end else begin
      m_y = 0;
    end
    if (c) begin
      m_cnt8 = 0; m_sat8 = 0;
      m_cnt2 = 0; m_sat2 = 0;
    end else if (match != 0) begin
      if (m_cnt8 < 255) begin m_cnt8++; if (m_cnt8 == 255) m_sat8 = 1; end
      if (m_cnt2 < 3)   begin m_cnt2++; if (m_cnt2 == 3)   m_sat2 = 1; end
    end
  endtask

  task automatic step(input logic r, d, v, l, input logic [3:0] p,
                      input logic o, c);
    @(negedge clk);
    rst = r; din = d; din_valid = v; load = l; pattern = p;
    overlap = o; clr_count = c;
    @(posedge clk);
    model_edge(r, d, v, l, p, o, c);
    #1;
    chk("y_a",   int'(y_a),   m_y);
    chk("y_b",   int'(y_b),   m_y);
    chk("cnt_a", int'(cnt_a), m_cnt8);
    chk("sat_a", int'(sat_a), m_sat8);
    chk("cnt_b", int'(cnt_b), m_cnt2);
    chk("sat_b", int'(sat_b), m_sat2);
  endtask

  // '1'/'0' present a valid bit, '-' is an idle (din_valid=0) cycle.
  task automatic send(input string s, input logic o);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, o, 1'b0);
      else             step(1'b0, s[i] == "1", 1'b1, 1'b0, 4'h0, o, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic o_r;
    do_reset();
    chk("rst_y", int'(y_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);

    // 1: single match with the reset pattern
    send("101", 1'b1);
    chk("t1_pre", int'(y_a), 0);
    send("0", 1'b1);
    chk("t1_y", int'(y_a), 1);
    chk("t1_cnt", int'(cnt_a), 1);
    send("-", 1'b1);
    chk("t1_y_drop", int'(y_a), 0);

    // 2: overlap vs non-overlap
    do_reset();
    send("101010", 1'b1);
    chk("t2_ovl_cnt", int'(cnt_a), 2);
    do_reset();
    send("101010", 1'b0);
    chk("t2_novl_cnt", int'(cnt_a), 1);

    // 3: load ignores that cycle's bit
    do_reset();
    send("11", 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0);
    chk("t3_load_y", int'(y_a), 0);
    send("1101", 1'b1);
    chk("t3_y", int'(y_a), 1);

    // 4: gaps do not break a partial match
    do_reset();
    send("10-----10", 1'b1);
    chk("t4_cnt", int'(cnt_a), 1);

    // 5: saturation on the 2-bit counter, then clear against a match
    do_reset();
    send("101010101010", 1'b1);
    chk("t5_cnt_b", int'(cnt_b), 3);
    chk("t5_sat_b", int'(sat_b), 1);
    send("1", 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t5_clr_y", int'(y_b), 1);
    chk("t5_clr_cnt", int'(cnt_b), 0);
    chk("t5_clr_sat", int'(sat_b), 0);

    // 6: reset mid-pattern restores the default pattern
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
    send("011", 1'b1);
    do_reset();
    send("0", 1'b1);
    chk("t6_y", int'(y_a), 0);
    send("1010", 1'b1);
    chk("t6_y2", int'(y_a), 1);

    // Random traffic
    o_r = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      logic r, l, c, v;
      if ($urandom_range(0, 63) == 0) o_r = ~o_r;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, 1'($urandom), v, l, 4'($urandom), o_r, c);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
